// File: rtl/sba_preload_seq.sv
// Streams a block of 32-bit words into system memory via the debug module's SBA registers over DMI:
// configure SBCS, set SBAddress0, push SBData0 with autoincrement, and poll SBCS at checkpoints.
module sba_preload_seq #(
   parameter int unsigned CheckEvery = 128,
   parameter int unsigned MaxRetries = 15,
   parameter int unsigned CntW       = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [31:0]     base_addr_i,
   input  logic [CntW-1:0] word_cnt_i,
   input  logic [31:0]     wdata_i,
   input  logic            wvalid_i,
   output logic            wready_o,
   output logic            dmi_req_valid_o,
   input  logic            dmi_req_ready_i,
   output logic [6:0]      dmi_req_addr_o,
   output logic [1:0]      dmi_req_op_o,
   output logic [31:0]     dmi_req_data_o,
   input  logic            dmi_resp_valid_i,
   output logic            dmi_resp_ready_o,
   input  logic [31:0]     dmi_resp_data_i,
   input  logic [1:0]      dmi_resp_op_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic [1:0]      err_code_o
);

   localparam int unsigned CkW = $clog2(CheckEvery + 1);
   localparam int unsigned RtW = $clog2(MaxRetries + 2);

   localparam logic [6:0]  AddrSbcs  = 7'h38;
   localparam logic [6:0]  AddrSbAdr = 7'h39;
   localparam logic [6:0]  AddrSbDat = 7'h3C;
   localparam logic [1:0]  OpRead    = 2'd1;
   localparam logic [1:0]  OpWrite   = 2'd2;
   localparam logic [31:0] SbcsCfg   = 32'h0005_0000;

   typedef enum logic [3:0] {
      S_IDLE, S_CFG_REQ, S_CFG_WAIT, S_ADDR_REQ, S_ADDR_WAIT, S_FETCH,
      S_DATA_REQ, S_DATA_WAIT, S_POLL_REQ, S_POLL_WAIT, S_DONE, S_ERR
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     base_q, base_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] wd_q, wd_d, wd_inc;
   logic [CkW-1:0]  ck_q, ck_d, ck_inc;
   logic [RtW-1:0]  retry_q, retry_d;
   logic [31:0]     hold_q, hold_d;
   logic            err_q, err_d;
   logic [1:0]      code_q, code_d;

   logic            req_valid_q, req_valid_d;
   logic [6:0]      req_addr_q, req_addr_d;
   logic [1:0]      req_op_q, req_op_d;
   logic [31:0]     req_data_q, req_data_d;
   logic            resp_ready_q, resp_ready_d;
   logic            wready_q, wready_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            req_fire, resp_take, resp_ok, resp_busy, resp_fail;
   logic            unused_resp_bits;

   assign req_fire  = req_valid_q && dmi_req_ready_i;
   assign resp_take = dmi_resp_valid_i && resp_ready_q;
   assign resp_ok   = resp_take && (dmi_resp_op_i == 2'd0);
   assign resp_busy = resp_take && (dmi_resp_op_i == 2'd3);
   assign resp_fail = resp_take && (dmi_resp_op_i != 2'd0) && (dmi_resp_op_i != 2'd3);
   assign unused_resp_bits = ^{dmi_resp_data_i[31:23], dmi_resp_data_i[20:15], dmi_resp_data_i[11:0]};

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      wd_d    = wd_q;
      ck_d    = ck_q;
      retry_d = retry_q;
      hold_d  = hold_q;
      err_d   = err_q;
      code_d  = code_q;
      wd_inc  = wd_q + CntW'(1);
      ck_inc  = ck_q + CkW'(1);

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               err_d  = 1'b0;
               code_d = 2'd0;
               if (word_cnt_i == '0) begin
                  state_d = S_DONE;
               end else begin
                  base_d  = base_addr_i;
                  cnt_d   = word_cnt_i;
                  wd_d    = '0;
                  ck_d    = '0;
                  retry_d = '0;
                  state_d = S_CFG_REQ;
               end
            end
         end
         S_CFG_REQ:  if (req_fire) state_d = S_CFG_WAIT;
         S_CFG_WAIT: begin
            if (resp_ok)        state_d = S_ADDR_REQ;
            else if (resp_busy) state_d = S_CFG_REQ;
         end
         S_ADDR_REQ:  if (req_fire) state_d = S_ADDR_WAIT;
         S_ADDR_WAIT: begin
            if (resp_ok)        state_d = S_FETCH;
            else if (resp_busy) state_d = S_ADDR_REQ;
         end
         S_FETCH: begin
            if (wvalid_i && wready_q) begin
               hold_d  = wdata_i;
               state_d = S_DATA_REQ;
            end
         end
         S_DATA_REQ:  if (req_fire) state_d = S_DATA_WAIT;
         S_DATA_WAIT: begin
            if (resp_ok) begin
               wd_d = wd_inc;
               // Last word and checkpoint coinciding still yields a single poll.
               if ((wd_inc == cnt_q) || (ck_inc == CkW'(CheckEvery))) begin
                  ck_d    = '0;
                  state_d = S_POLL_REQ;
               end else begin
                  ck_d    = ck_inc;
                  state_d = S_FETCH;
               end
            end else if (resp_busy) begin
               state_d = S_DATA_REQ;
            end
         end
         S_POLL_REQ:  if (req_fire) state_d = S_POLL_WAIT;
         S_POLL_WAIT: begin
            if (resp_ok) begin
               if (dmi_resp_data_i[22] || (dmi_resp_data_i[14:12] != 3'd0)) begin
                  state_d = S_ERR;
                  code_d  = 2'd3;
               end else if (dmi_resp_data_i[21]) begin
                  state_d = S_POLL_REQ;
               end else if (wd_q == cnt_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FETCH;
               end
            end else if (resp_busy) begin
               state_d = S_POLL_REQ;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Retry accounting shared by every WAIT phase; sbbusy re-reads arrive as success.
      if (resp_ok) retry_d = '0;
      if (resp_busy) begin
         if (retry_q == RtW'(MaxRetries)) begin
            state_d = S_ERR;
            code_d  = 2'd2;
         end else begin
            retry_d = retry_q + RtW'(1);
         end
      end
      if (resp_fail) begin
         state_d = S_ERR;
         code_d  = 2'd1;
      end
      if (state_d == S_ERR) err_d = 1'b1;
   end

   // Registered outputs derived from the state being entered.
   always_comb begin
      req_valid_d = 1'b0;
      req_addr_d  = req_addr_q;
      req_op_d    = req_op_q;
      req_data_d  = req_data_q;
      case (state_d)
         S_CFG_REQ: begin
            req_valid_d = 1'b1;
            req_addr_d  = AddrSbcs;
            req_op_d    = OpWrite;
            req_data_d  = SbcsCfg;
         end
         S_ADDR_REQ: begin
            req_valid_d = 1'b1;
            req_addr_d  = AddrSbAdr;
            req_op_d    = OpWrite;
            req_data_d  = base_d;
         end
         S_DATA_REQ: begin
            req_valid_d = 1'b1;
            req_addr_d  = AddrSbDat;
            req_op_d    = OpWrite;
            req_data_d  = hold_d;
         end
         S_POLL_REQ: begin
            req_valid_d = 1'b1;
            req_addr_d  = AddrSbcs;
            req_op_d    = OpRead;
            req_data_d  = 32'h0;
         end
         default: req_valid_d = 1'b0;
      endcase
      resp_ready_d = (state_d == S_CFG_WAIT) || (state_d == S_ADDR_WAIT) ||
                     (state_d == S_DATA_WAIT) || (state_d == S_POLL_WAIT);
      wready_d     = (state_d == S_FETCH);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         base_q       <= '0;
         cnt_q        <= '0;
         wd_q         <= '0;
         ck_q         <= '0;
         retry_q      <= '0;
         hold_q       <= '0;
         err_q        <= 1'b0;
         code_q       <= 2'd0;
         req_valid_q  <= 1'b0;
         req_addr_q   <= '0;
         req_op_q     <= '0;
         req_data_q   <= '0;
         resp_ready_q <= 1'b0;
         wready_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         cnt_q        <= cnt_d;
         wd_q         <= wd_d;
         ck_q         <= ck_d;
         retry_q      <= retry_d;
         hold_q       <= hold_d;
         err_q        <= err_d;
         code_q       <= code_d;
         req_valid_q  <= req_valid_d;
         req_addr_q   <= req_addr_d;
         req_op_q     <= req_op_d;
         req_data_q   <= req_data_d;
         resp_ready_q <= resp_ready_d;
         wready_q     <= wready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign wready_o         = wready_q;
   assign dmi_req_valid_o  = req_valid_q;
   assign dmi_req_addr_o   = req_addr_q;
   assign dmi_req_op_o     = req_op_q;
   assign dmi_req_data_o   = req_data_q;
   assign dmi_resp_ready_o = resp_ready_q;
   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign err_o            = err_q;
   assign err_code_o       = code_q;

endmodule

// File: tb/tb_sba_preload_seq.sv
// Directed bench: two instances (default checkpoint and CheckEvery=2) behind a shared DMI slave model.
module tb_sba_preload_seq;

   typedef struct packed {
      logic [6:0]  addr;
      logic [1:0]  op;
      logic [31:0] data;
   } req_t;

   logic        clk, rst, start, sel;
   logic [31:0] base_addr, wdata;
   logic [15:0] word_cnt;
   logic        wvalid;
   logic        dmi_req_ready;
   logic        dmi_resp_valid;
   logic [31:0] dmi_resp_data;
   logic [1:0]  dmi_resp_op;
   logic        start_a, start_b;

   logic        a_wready, a_req_valid, a_resp_ready, a_busy, a_done, a_err;
   logic [6:0]  a_req_addr;
   logic [1:0]  a_req_op, a_err_code;
   logic [31:0] a_req_data;
   logic        b_wready, b_req_valid, b_resp_ready, b_busy, b_done, b_err;
   logic [6:0]  b_req_addr;
   logic [1:0]  b_req_op, b_err_code;
   logic [31:0] b_req_data;

   logic        m_wready, m_req_valid, m_resp_ready, m_busy, m_done, m_err;
   logic [6:0]  m_req_addr;
   logic [1:0]  m_req_op, m_err_code;
   logic [31:0] m_req_data;
   logic [48:0] a_outs, b_outs;

   assign start_a = start & ~sel;
   assign start_b = start & sel;

   sba_preload_seq u_dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start_a), .base_addr_i(base_addr), .word_cnt_i(word_cnt),
      .wdata_i(wdata), .wvalid_i(wvalid), .wready_o(a_wready),
      .dmi_req_valid_o(a_req_valid), .dmi_req_ready_i(dmi_req_ready), .dmi_req_addr_o(a_req_addr),
      .dmi_req_op_o(a_req_op), .dmi_req_data_o(a_req_data),
      .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(a_resp_ready),
      .dmi_resp_data_i(dmi_resp_data), .dmi_resp_op_i(dmi_resp_op),
      .busy_o(a_busy), .done_o(a_done), .err_o(a_err), .err_code_o(a_err_code)
   );

   sba_preload_seq #(.CheckEvery(2)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .base_addr_i(base_addr), .word_cnt_i(word_cnt),
      .wdata_i(wdata), .wvalid_i(wvalid), .wready_o(b_wready),
      .dmi_req_valid_o(b_req_valid), .dmi_req_ready_i(dmi_req_ready), .dmi_req_addr_o(b_req_addr),
      .dmi_req_op_o(b_req_op), .dmi_req_data_o(b_req_data),
      .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(b_resp_ready),
      .dmi_resp_data_i(dmi_resp_data), .dmi_resp_op_i(dmi_resp_op),
      .busy_o(b_busy), .done_o(b_done), .err_o(b_err), .err_code_o(b_err_code)
   );

   assign m_wready     = sel ? b_wready     : a_wready;
   assign m_req_valid  = sel ? b_req_valid  : a_req_valid;
   assign m_req_addr   = sel ? b_req_addr   : a_req_addr;
   assign m_req_op     = sel ? b_req_op     : a_req_op;
   assign m_req_data   = sel ? b_req_data   : a_req_data;
   assign m_resp_ready = sel ? b_resp_ready : a_resp_ready;
   assign m_busy       = sel ? b_busy       : a_busy;
   assign m_done       = sel ? b_done       : a_done;
   assign m_err        = sel ? b_err        : a_err;
   assign m_err_code   = sel ? b_err_code   : a_err_code;
   assign a_outs = {a_req_valid, a_req_addr, a_req_op, a_req_data, a_resp_ready, a_wready,
                    a_busy, a_done, a_err, a_err_code};
   assign b_outs = {b_req_valid, b_req_addr, b_req_op, b_req_data, b_resp_ready, b_wready,
                    b_busy, b_done, b_err, b_err_code};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // DMI slave model state and knobs
   req_t        req_log[$];
   logic [31:0] poll_q[$];
   logic [31:0] src_q[$];
   logic [6:0]  busy_addr = 7'h7F;
   int          busy_left = 0;
   logic [6:0]  fail_addr = 7'h7F;
   logic [6:0]  hold_addr = 7'h3C;
   logic        hold_en = 1'b0, hold_rel = 1'b0, resp_drop = 1'b0;
   logic        held, req_hs, resp_hs, w_hs;
   req_t        cap;

   initial begin : dmi_slave
      dmi_req_ready  = 1'b1;
      dmi_resp_valid = 1'b0;
      dmi_resp_op    = 2'd0;
      dmi_resp_data  = 32'h0;
      req_hs = 1'b0; resp_hs = 1'b0; held = 1'b0; cap = '0;
      forever begin
         @(negedge clk);
         if (resp_hs) dmi_resp_valid = 1'b0;
         if (req_hs) begin
            req_log.push_back(cap);
            dmi_resp_data = 32'h0;
            dmi_resp_op   = 2'd0;
            if (cap.addr == busy_addr && busy_left > 0) begin
               dmi_resp_op = 2'd3;
               busy_left--;
            end else if (cap.addr == fail_addr) begin
               dmi_resp_op = 2'd2;
            end else if (cap.op == 2'd1 && poll_q.size() > 0) begin
               dmi_resp_data = poll_q.pop_front();
            end
            if (hold_en && cap.addr == hold_addr) held = 1'b1;
            else dmi_resp_valid = 1'b1;
         end
         if (held && hold_rel) begin
            dmi_resp_valid = 1'b1;
            held = 1'b0;
         end
         if (resp_drop) begin
            dmi_resp_valid = 1'b0;
            held = 1'b0;
         end
         req_hs  = m_req_valid && dmi_req_ready;
         cap     = {m_req_addr, m_req_op, m_req_data};
         resp_hs = dmi_resp_valid && m_resp_ready;
      end
   end

   initial begin : word_src
      logic [31:0] dummy;
      wvalid = 1'b0; wdata = 32'h0; w_hs = 1'b0;
      forever begin
         @(negedge clk);
         if (w_hs && src_q.size() > 0) dummy = src_q.pop_front();
         wvalid = (src_q.size() > 0);
         wdata  = (src_q.size() > 0) ? src_q[0] : 32'h0;
         w_hs   = wvalid && m_wready;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic req_t rq(input logic [6:0] a, input logic [1:0] o, input logic [31:0] d);
      return {a, o, d};
   endfunction

   task automatic check_req(input string tag, input int idx, input req_t exp);
      req_t got;
      got = '1;
      if (idx < req_log.size()) got = req_log[idx];
      check_eq($sformatf("%s[%0d]", tag, idx), 64'(got), 64'(exp));
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic launch(input logic s, input logic [31:0] base, input logic [15:0] cnt);
      sel = s;
      req_log.delete();
      base_addr = base;
      word_cnt  = cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag, output logic saw_done, output logic saw_err);
      for (int k = 0; k < 3000; k++) begin
         tick();
         if (m_done || m_err) break;
      end
      saw_done = m_done;
      saw_err  = m_err;
      check_eq({tag, "_finished"}, 64'(saw_done | saw_err), 64'(1));
   endtask

   function automatic int count_addr(input logic [6:0] a);
      int n = 0;
      foreach (req_log[i]) if (req_log[i].addr == a) n++;
      return n;
   endfunction

   localparam req_t CFG  = {7'h38, 2'd2, 32'h0005_0000};
   localparam req_t POLL = {7'h38, 2'd1, 32'h0};

   initial begin : main
      logic d, e, ok;
      int   bad;
      req_t ex[$];

      rst = 1'b1; start = 1'b0; sel = 1'b0; base_addr = 32'h0; word_cnt = 16'h0;
      repeat (3) tick();
      check_eq("rst_outs_a", 64'(a_outs), 64'(0));
      check_eq("rst_outs_b", 64'(b_outs), 64'(0));
      rst = 1'b0;
      tick();

      // Basic 3-word transfer, single final poll
      src_q = '{32'hA, 32'hB, 32'hC};
      launch(1'b0, 32'h0000_1000, 16'd3);
      wait_end("t1", d, e);
      check_eq("t1_done", 64'(d), 64'(1));
      check_eq("t1_err", 64'(e), 64'(0));
      check_eq("t1_nreq", 64'(req_log.size()), 64'(6));
      ex = '{CFG, rq(7'h39, 2'd2, 32'h1000), rq(7'h3C, 2'd2, 32'hA), rq(7'h3C, 2'd2, 32'hB),
             rq(7'h3C, 2'd2, 32'hC), POLL};
      foreach (ex[i]) check_req("t1_req", i, ex[i]);
      tick();
      check_eq("t1_after_busy_done", 64'({m_busy, m_done}), 64'(0));

      // CheckEvery=2: polls after word 2 and 4, one extra read on sbbusy
      poll_q = '{32'h0020_0000};
      src_q  = '{32'h1, 32'h2, 32'h3, 32'h4};
      launch(1'b1, 32'h0000_2000, 16'd4);
      wait_end("t2", d, e);
      check_eq("t2_done", 64'(d), 64'(1));
      check_eq("t2_nreq", 64'(req_log.size()), 64'(9));
      ex = '{CFG, rq(7'h39, 2'd2, 32'h2000), rq(7'h3C, 2'd2, 32'h1), rq(7'h3C, 2'd2, 32'h2),
             POLL, POLL, rq(7'h3C, 2'd2, 32'h3), rq(7'h3C, 2'd2, 32'h4), POLL};
      foreach (ex[i]) check_req("t2_req", i, ex[i]);
      tick();

      // Three busy responses on the SBAddress0 write are absorbed
      busy_addr = 7'h39; busy_left = 3;
      src_q = '{32'h55};
      launch(1'b0, 32'h0000_3000, 16'd1);
      wait_end("t3a", d, e);
      check_eq("t3a_done", 64'(d), 64'(1));
      ex = '{CFG, rq(7'h39, 2'd2, 32'h3000), rq(7'h39, 2'd2, 32'h3000), rq(7'h39, 2'd2, 32'h3000),
             rq(7'h39, 2'd2, 32'h3000), rq(7'h3C, 2'd2, 32'h55), POLL};
      check_eq("t3a_nreq", 64'(req_log.size()), 64'(7));
      foreach (ex[i]) check_req("t3a_req", i, ex[i]);
      tick();

      // Sixteen busy responses exceed the retry budget
      busy_left = 16;
      src_q = '{32'h1, 32'h2};
      launch(1'b0, 32'h0000_4000, 16'd2);
      wait_end("t3b", d, e);
      check_eq("t3b_err", 64'({d, e, m_err_code}), 64'({1'b0, 1'b1, 2'd2}));
      check_eq("t3b_nreq", 64'(req_log.size()), 64'(17));
      check_eq("t3b_no_sbdata", 64'(count_addr(7'h3C)), 64'(0));
      tick();
      check_eq("t3b_idle_sticky", 64'({m_busy, m_err, m_err_code}), 64'({1'b0, 1'b1, 2'd2}));
      busy_addr = 7'h7F; busy_left = 0;

      // Poll reports sberror
      poll_q = '{32'h0000_1000};
      src_q  = '{32'h77};
      launch(1'b0, 32'h0000_5000, 16'd1);
      wait_end("t4", d, e);
      check_eq("t4_err", 64'({d, e, m_err_code}), 64'({1'b0, 1'b1, 2'd3}));
      tick();
      check_eq("t4_idle", 64'({m_busy, m_done, m_err, m_err_code}), 64'({1'b0, 1'b0, 1'b1, 2'd3}));

      // Zero-count start: done next cycle, error cleared, no DMI traffic
      src_q.delete();
      launch(1'b0, 32'h0000_6000, 16'd0);
      check_eq("t5a_done", 64'({m_done, m_err, m_err_code}), 64'({1'b1, 1'b0, 2'd0}));
      tick();
      check_eq("t5a_after", 64'({m_done, m_busy}), 64'(0));
      tick();
      check_eq("t5a_nreq", 64'(req_log.size()), 64'(0));

      // Failed DMI response
      fail_addr = 7'h38;
      launch(1'b0, 32'h0000_7000, 16'd1);
      wait_end("tf", d, e);
      check_eq("tf_err", 64'({d, e, m_err_code}), 64'({1'b0, 1'b1, 2'd1}));
      check_eq("tf_nreq", 64'(req_log.size()), 64'(1));
      fail_addr = 7'h7F;
      tick();

      // Source stalls mid-stream; start while busy is ignored
      src_q = '{32'h11};
      launch(1'b0, 32'h0000_8000, 16'd3);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (m_wready && src_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check_eq("t5b_fetch_reached", 64'(ok), 64'(1));
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         start     = (i == 5);
         base_addr = 32'h9999_0000;
         word_cnt  = 16'd0;
         tick();
         if (m_req_valid || !m_wready || m_done) bad++;
      end
      start = 1'b0;
      check_eq("t5b_stall_quiet", 64'(bad), 64'(0));
      src_q.push_back(32'h22);
      src_q.push_back(32'h33);
      wait_end("t5b", d, e);
      check_eq("t5b_done", 64'({d, e}), 64'({1'b1, 1'b0}));
      check_eq("t5b_nreq", 64'(req_log.size()), 64'(6));
      check_req("t5b_req", 1, rq(7'h39, 2'd2, 32'h8000));
      check_req("t5b_req", 4, rq(7'h3C, 2'd2, 32'h33));
      tick();

      // Reset during DATA wait; late response ignored; clean restart
      hold_en = 1'b1;
      src_q = '{32'hAA, 32'hBB};
      launch(1'b0, 32'h0000_A000, 16'd2);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (m_resp_ready && req_log.size() > 0 && req_log[req_log.size()-1].addr == 7'h3C) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check_eq("t6_data_wait", 64'(ok), 64'(1));
      rst = 1'b1;
      tick();
      check_eq("t6_rst_outs", 64'(a_outs), 64'(0));
      rst = 1'b0;
      hold_rel = 1'b1;
      repeat (3) tick();
      check_eq("t6_late_ignored", 64'({m_busy, m_req_valid, m_resp_ready, m_done, m_err}), 64'(0));
      hold_rel = 1'b0; hold_en = 1'b0; resp_drop = 1'b1;
      tick();
      resp_drop = 1'b0;
      tick();
      src_q = '{32'hCC};
      launch(1'b0, 32'h0000_B000, 16'd1);
      wait_end("t6", d, e);
      check_eq("t6_done", 64'({d, e}), 64'({1'b1, 1'b0}));
      check_eq("t6_nreq", 64'(req_log.size()), 64'(4));
      check_req("t6_req", 0, CFG);
      check_req("t6_req", 1, rq(7'h39, 2'd2, 32'hB000));
      check_req("t6_req", 2, rq(7'h3C, 2'd2, 32'hCC));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sba_preload_seq.md
Name: sba_preload_seq

Overview:
- Hardware sequencer that streams a block of 32-bit words into system memory through the debug module's System Bus Access (SBA) registers over the DMI port.
- Performs in RTL what the JTAG ELF preload flow does in software: configure SBCS, write SBAddress0, push SBData0 with autoincrement, and poll SBCS for busy/error at checkpoints.
- Sits between a word source (boot-ROM copier or UART loader) and the DMI request/response port of the debug module.

Parameters:
- CheckEvery, 128, words written between SBCS busy/error polls; must be ≥1.
- MaxRetries, 15, consecutive DMI "busy" responses tolerated per request before error.
- CntW, 16, width of word-count input.

Ports:
- clk_i, in, 1, system clock.
- rst_i, in, 1, synchronous active-high reset.
- start_i, in, 1, one-cycle pulse; accepted only in IDLE.
- base_addr_i, in, 32, word-aligned target start address; sampled on start_i.
- word_cnt_i, in, CntW, number of words to write; sampled on start_i.
- wdata_i, in, 32, word stream data.
- wvalid_i, in, 1, word stream valid.
- wready_o, out, 1, word stream ready.
- dmi_req_valid_o, out, 1, DMI request valid.
- dmi_req_ready_i, in, 1, DMI request ready.
- dmi_req_addr_o, out, 7, DMI register address.
- dmi_req_op_o, out, 2, 1 = read, 2 = write.
- dmi_req_data_o, out, 32, DMI write data.
- dmi_resp_valid_i, in, 1, DMI response valid.
- dmi_resp_ready_o, out, 1, DMI response ready.
- dmi_resp_data_i, in, 32, DMI read data.
- dmi_resp_op_i, in, 2, 0 = success, 2 = failed, 3 = busy.
- busy_o, out, 1, high whenever not IDLE.
- done_o, out, 1, one-cycle pulse on successful completion.
- err_o, out, 1, sticky error; cleared by the next accepted start_i or by reset.
- err_code_o, out, 2, 1 = DMI failed, 2 = retry overflow, 3 = SBCS sberror or sbbusyerror set.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is rst_i, synchronous and active-high. During reset all outputs are 0, the FSM is in IDLE, and counters are cleared. Asserting rst_i mid-operation abandons the transfer immediately; an outstanding DMI response arriving after reset is ignored.
- Request/response discipline:
  - At most one DMI request is outstanding at a time.
  - dmi_req_* stays stable from valid until the cycle valid & ready are both high.
  - dmi_resp_ready_o is high only in the WAIT sub-state that follows each accepted request.
- Response handling:
  - Busy response (3): re-issue the identical request on the next cycle and increment the retry counter. Success clears the counter. When the counter would exceed MaxRetries, go to ERR with code 2.
  - Failed response (2): go to ERR with code 1.
- FSM states: IDLE, CFG, ADDR, FETCH, DATA, POLL, DONE, ERR. Each DMI-issuing state has its own issue and WAIT phases.
- IDLE:
  - On start_i with word_cnt_i == 0: pulse done_o the next cycle and issue no DMI traffic.
  - On start_i otherwise: latch inputs, clear err_o, go to CFG.
- CFG: write DMI addr 0x38 (SBCS), data 0x0005_0000 (sbaccess = 2, sbautoincrement = 1). Then go to ADDR.
- ADDR: write 0x39 (SBAddress0) with base_addr. Then go to FETCH.
- FETCH: wready_o = 1. On wvalid_i & wready_o, capture the word into a holding register and go to DATA. wready_o is 0 in every other state.
- DATA: write 0x3C (SBData0) with the held word. On success, increment words_done and the checkpoint counter.
  - If words_done == count, or the checkpoint counter == CheckEvery: go to POLL and clear the checkpoint counter.
  - Otherwise go back to FETCH.
- POLL: read 0x38.
  - If resp bit 22 (sbbusyerror) is set or bits 14:12 (sberror) ≠ 0: go to ERR with code 3.
  - Else if bit 21 (sbbusy) is set: re-issue the read (does not count toward MaxRetries).
  - Else go to DONE if words_done == count, otherwise FETCH.
- DONE: done_o pulses for one cycle, then go to IDLE.
- ERR: set err_o and err_code_o, then go to IDLE the next cycle.
- start_i while busy_o = 1 is ignored.
- words_done is CntW bits wide; word_cnt_i = 2^CntW − 1 must complete without wrap.
- The final poll always occurs, even if count is a multiple of CheckEvery. In that case exactly one poll follows the last word, not two.

Test Plan:
1. base 0x0000_1000, count 3, data 0xA,0xB,0xC, DMI always ready/success → DMI writes in order (0x38, 0x0005_0000), (0x39, 0x1000), (0x3C, 0xA/0xB/0xC), then one read of 0x38 returning 0; done_o pulses; err_o = 0.
2. CheckEvery = 2, count 4 → SBCS read after word 2 and after word 4 only; an sbbusy = 1 response once at the first poll causes exactly one extra read.
3. Busy response returned 3 times on the ADDR write (MaxRetries = 15) → identical request re-issued 3 times, then transfer completes. With 16 busy responses → err_o = 1, err_code_o = 2, no SBData0 write issued.
4. Poll returns 0x0000_1000 (sberror = 1) → err_code_o = 3, no done_o, IDLE next cycle; a new start_i clears err_o.
5. count 0 → done_o one cycle after start_i, zero DMI requests. Source holds wvalid_i low for 20 cycles mid-stream → FSM waits in FETCH with dmi_req_valid_o = 0.
6. rst_i asserted during DATA WAIT → all outputs 0 next cycle; a late dmi_resp_valid_i is ignored; a fresh start_i runs cleanly from CFG.
